murmur_arbiter: RTL and testbench

MURMUR_ARBITER -- requirements
Module: murmur_arbiter

---
 rtl/murmur_arbiter_pkg.sv | 19 +
 rtl/murmur_arbiter_if.sv | 60 ++++++
 rtl/murmur_arbiter_rr_grant.sv | 30 +++
 rtl/murmur_arbiter.sv | 137 +++++++++++++
 tb/tb_murmur_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/murmur_arbiter_pkg.sv
// murmur_pkg: shared tuple/hash types and widths for the murmur arbiter slice.
package murmur_pkg;

  localparam int unsigned KEY_BITS     = 32;
  localparam int unsigned PAYLOAD_BITS = 32;
  localparam int unsigned HASH_BITS    = 96;
  localparam int unsigned SERIAL_BITS  = 64;
  localparam int unsigned MAX_NUM_SRC  = 8;
  localparam int unsigned CNT_BITS     = 4;

  typedef struct packed {
    logic [PAYLOAD_BITS-1:0] payload;
    logic [KEY_BITS-1:0]     key;
  } tuple_t;

  typedef logic [HASH_BITS-1:0]   hashed_t;
  typedef logic [SERIAL_BITS-1:0] serial_t;

endpackage

// File: rtl/murmur_arbiter_if.sv
// murmur_arbiter_if: source, hash-unit and result buses of murmur_arbiter.
//   slave  : arbiter view (sources/results/hash unit on the far side)
//   master : environment view
interface murmur_arbiter_if
  import murmur_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
);

  logic    [NUM_SRC-1:0] s_valid;
  logic    [NUM_SRC-1:0] s_ready;
  tuple_t  [NUM_SRC-1:0] s_data;
  logic    [NUM_SRC-1:0] s_last_processed;
  serial_t [NUM_SRC-1:0] s_serialnum;

  logic    h_in_valid;
  logic    h_in_ready;
  tuple_t  h_in_data;
  logic    h_in_last_processed;
  serial_t h_in_serialnum;

  logic    h_out_valid;
  logic    h_out_ready;
  hashed_t h_out_data;
  logic    h_out_last_processed;
  serial_t h_out_serialnum;

  logic    [NUM_SRC-1:0] m_valid;
  logic    [NUM_SRC-1:0] m_ready;
  hashed_t [NUM_SRC-1:0] m_data;
  logic    [NUM_SRC-1:0] m_last_processed;
  serial_t [NUM_SRC-1:0] m_serialnum;

  logic    busy;

  modport slave (
    input  s_valid, s_data, s_last_processed, s_serialnum,
    output s_ready,
    output h_in_valid, h_in_data, h_in_last_processed, h_in_serialnum,
    input  h_in_ready,
    input  h_out_valid, h_out_data, h_out_last_processed, h_out_serialnum,
    output h_out_ready,
    output m_valid, m_data, m_last_processed, m_serialnum,
    input  m_ready,
    output busy
  );

  modport master (
    output s_valid, s_data, s_last_processed, s_serialnum,
    input  s_ready,
    input  h_in_valid, h_in_data, h_in_last_processed, h_in_serialnum,
    output h_in_ready,
    output h_out_valid, h_out_data, h_out_last_processed, h_out_serialnum,
    input  h_out_ready,
    input  m_valid, m_data, m_last_processed, m_serialnum,
    output m_ready,
    input  busy
  );

endinterface

// File: rtl/murmur_arbiter_rr_grant.sv
// rr_grant: combinational round-robin pick, searching upward from ptr_i.
module rr_grant #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] id_o,
  output logic           valid_o
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = IDW'((32'(ptr_i) + off) % N);
      if (!valid_o && req_i[idx]) begin
        valid_o      = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = idx;
      end
    end
  end

endmodule

// File: rtl/murmur_arbiter.sv
// murmur_arbiter: N tuple streams share one hash unit; source id rides in the
// top IDW serialnum bits and steers results back. Optional burst lock via
// MURMUR_ARB_LOCK_EN.
module murmur_arbiter
  import murmur_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDW     = $clog2(NUM_SRC)
) (
  input  logic           clk,
  input  logic           reset,
  murmur_arbiter_if.slave bus
);

  if (NUM_SRC < 2 || NUM_SRC > MAX_NUM_SRC) begin : g_bad_num_src
    $error("murmur_arbiter: NUM_SRC out of range");
  end

  logic [NUM_SRC-1:0]  req;
  logic [NUM_SRC-1:0]  grant;
  logic [IDW-1:0]      gid;
  logic                gvalid;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      dst;
  logic                dst_ready;
  logic                dst_hit;
  logic                issue_xfer;
  logic                ret_xfer;
  logic [CNT_BITS-1:0] inflight_q, inflight_d;
  serial_t             sn_sel;

`ifdef MURMUR_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_e;
  state_e         state_q, state_d;
  logic [IDW-1:0] lock_q, lock_d;

  always_comb begin
    req = bus.s_valid;
    if (state_q == LOCKED) req = bus.s_valid & (NUM_SRC'(1) << lock_q);
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      ARB:     if (issue_xfer && !bus.h_in_last_processed) begin
                 state_d = LOCKED;
                 lock_d  = gid;
               end
      LOCKED:  if (issue_xfer && bus.h_in_last_processed) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end
`else
  always_comb req = bus.s_valid;
`endif

  rr_grant #(.N(NUM_SRC), .IDW(IDW)) u_rr_grant (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .id_o    (gid),
    .valid_o (gvalid)
  );

  always_comb begin
    sn_sel                  = bus.s_serialnum[gid];
    bus.h_in_valid          = gvalid && !reset;
    bus.s_ready             = (bus.h_in_ready && !reset) ? grant : '0;
    bus.h_in_data           = bus.s_data[gid];
    bus.h_in_last_processed = bus.s_last_processed[gid];
    bus.h_in_serialnum      = {gid, sn_sel[SERIAL_BITS-1-IDW:0]};
  end

  assign dst = bus.h_out_serialnum[SERIAL_BITS-1 -: IDW];

  // ids with no matching source never hit, so they drain with ready held high
  always_comb begin
    dst_ready   = 1'b0;
    dst_hit     = 1'b0;
    bus.m_valid = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (32'(dst) == i) begin
        dst_hit        = 1'b1;
        dst_ready      = bus.m_ready[i];
        bus.m_valid[i] = bus.h_out_valid && !reset;
      end
    end
    bus.h_out_ready = !reset && (!bus.h_out_valid || !dst_hit || dst_ready);
  end

  always_comb begin
    bus.m_data           = '0;
    bus.m_last_processed = '0;
    bus.m_serialnum      = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      bus.m_data[i]           = bus.h_out_data;
      bus.m_last_processed[i] = bus.h_out_last_processed;
      bus.m_serialnum[i]      = {{IDW{1'b0}}, bus.h_out_serialnum[SERIAL_BITS-1-IDW:0]};
    end
  end

  assign issue_xfer = bus.h_in_valid && bus.h_in_ready;
  assign ret_xfer   = bus.h_out_valid && bus.h_out_ready;
  assign bus.busy   = (inflight_q != '0) || (|bus.s_valid);

  always_comb begin
    ptr_d = ptr_q;
    if (issue_xfer) ptr_d = (32'(gid) == NUM_SRC - 1) ? '0 : gid + 1'b1;
    inflight_d = inflight_q;
    if (issue_xfer && !ret_xfer && inflight_q != '1)
      inflight_d = inflight_q + 1'b1;
    else if (ret_xfer && !issue_xfer && inflight_q != '0)
      inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_murmur_arbiter.sv
module tb_murmur_arbiter;
  import murmur_pkg::*;

  localparam int unsigned NS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  murmur_arbiter_if #(.NUM_SRC(NS)) bus ();
  murmur_arbiter_if #(.NUM_SRC(3))  bus3 ();

  murmur_arbiter #(.NUM_SRC(NS), .IDW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  murmur_arbiter #(.NUM_SRC(3), .IDW(2)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  typedef struct {
    int unsigned id;
    serial_t     serial;
    tuple_t      data;
  } iss_t;

  typedef struct {
    serial_t serial;
    hashed_t data;
    logic    last;
  } beat_t;

  typedef struct {
    int unsigned dst;
    serial_t     serial;
    hashed_t     data;
    logic        last;
  } ret_t;

  iss_t  iss_q[$];
  beat_t drv_q[$];
  ret_t  ret_q[$];

  int checks    = 0;
  int errors    = 0;
  int model_cnt = 0;
  int beats1    = 0;
  int n         = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cnt_inc();
    if (model_cnt < 15) model_cnt++;
  endtask

  task automatic cnt_dec();
    if (model_cnt > 0) model_cnt--;
  endtask

  task automatic push_iss(input int unsigned id);
    iss_t    e;
    serial_t sn;
    sn       = bus.s_serialnum[id];
    e.id     = id;
    e.serial = {id[1:0], sn[61:0]};
    e.data   = bus.s_data[id];
    iss_q.push_back(e);
  endtask

  task automatic push_ret(input int unsigned dst, input serial_t low, input hashed_t data,
                          input logic last);
    beat_t b;
    ret_t  r;
    b.serial = {dst[1:0], low[61:0]};
    b.data   = data;
    b.last   = last;
    r.dst    = dst;
    r.serial = {2'b00, low[61:0]};
    r.data   = data;
    r.last   = last;
    drv_q.push_back(b);
    ret_q.push_back(r);
  endtask

  task automatic run_issue(input int unsigned budget);
    int unsigned k;
    k = 0;
    while (iss_q.size() != 0 && k < budget) begin
      #1;
      if (bus.h_in_valid && bus.h_in_ready) begin
        iss_t       e;
        logic [3:0] oh;
        e      = iss_q.pop_front();
        oh     = '0;
        oh[e.id] = 1'b1;
        chk("issue_s_ready", bus.s_ready, oh);
        chk("issue_serial", bus.h_in_serialnum, e.serial);
        chk("issue_data", bus.h_in_data, e.data);
        cnt_inc();
      end
      tick();
      k++;
    end
    if (iss_q.size() != 0) begin
      chk("issue_timeout", iss_q.size(), 0);
      iss_q.delete();
    end
  endtask

  task automatic run_ret(input int unsigned budget);
    int unsigned k;
    k = 0;
    while (drv_q.size() != 0 && k < budget) begin
      bus.h_out_valid          = 1'b1;
      bus.h_out_serialnum      = drv_q[0].serial;
      bus.h_out_data           = drv_q[0].data;
      bus.h_out_last_processed = drv_q[0].last;
      #1;
      if (bus.h_out_ready) begin
        ret_t       e;
        logic [3:0] oh;
        e = ret_q.pop_front();
        void'(drv_q.pop_front());
        oh        = '0;
        oh[e.dst] = 1'b1;
        chk("ret_m_valid", bus.m_valid, oh);
        chk("ret_serial", bus.m_serialnum[e.dst], e.serial);
        chk("ret_data", bus.m_data[e.dst], e.data);
        chk("ret_last", bus.m_last_processed[e.dst], e.last);
        cnt_dec();
      end
      tick();
      k++;
    end
    bus.h_out_valid = 1'b0;
    if (drv_q.size() != 0) begin
      chk("ret_timeout", drv_q.size(), 0);
      drv_q.delete();
      ret_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_serialnum[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 17 + 3);
      bus.s_data[i]      = {32'hA000_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
    end
    for (int i = 0; i < 3; i++) begin
      bus3.s_serialnum[i] = '0;
      bus3.s_data[i]      = '0;
    end
    bus.s_last_processed      = '1;
    bus.h_out_data            = '0;
    bus.h_out_last_processed  = 1'b0;
    bus.m_ready               = '1;
    bus3.s_valid              = '0;
    bus3.s_last_processed     = '1;
    bus3.h_in_ready           = 1'b0;
    bus3.h_out_valid          = 1'b0;
    bus3.h_out_data           = '0;
    bus3.h_out_last_processed = 1'b0;
    bus3.h_out_serialnum      = '0;
    bus3.m_ready              = '0;

    // outputs held quiet while reset is high even with traffic offered
    bus.s_valid         = 4'hF;
    bus.h_in_ready      = 1'b1;
    bus.h_out_valid     = 1'b1;
    bus.h_out_serialnum = 64'h4000_0000_0000_0001;
    tick();
    tick();
    #1;
    chk("rst_h_in_valid", bus.h_in_valid, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_h_out_ready", bus.h_out_ready, 0);
    chk("rst_inflight", dut.inflight_q, 0);
    chk("rst_ptr", dut.ptr_q, 0);
    bus.s_valid     = '0;
    bus.h_in_ready  = 1'b0;
    bus.h_out_valid = 1'b0;
    reset           = 1'b0;
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_h_out_ready", bus.h_out_ready, 1);
    tick();

    // all four requesting: 0,1,2,3,0
    bus.s_valid    = 4'hF;
    bus.h_in_ready = 1'b1;
    for (int unsigned k = 0; k < 5; k++) push_iss(k % 4);
    run_issue(10);
    bus.s_valid = '0;
    #1;
    chk("a_busy", bus.busy, 1);
    chk("a_inflight", dut.inflight_q, model_cnt);
    tick();

    // lone source 2, serialnum 5
    bus.s_serialnum[2] = 64'h5;
    bus.s_valid        = 4'b0100;
    push_iss(2);
    #1;
    chk("b_serial_lit", bus.h_in_serialnum, 64'h8000_0000_0000_0005);
    run_issue(4);
    bus.s_valid = '0;
    push_ret(2, 64'h5, 96'hDEAD_BEEF_0123_4567_89AB_CDEF, 1'b1);
    run_ret(4);

    // destination 1 back-pressured for three cycles
    push_ret(1, 64'h77, 96'h1111_2222_3333_4444_5555_6666, 1'b0);
    bus.m_ready              = 4'b1101;
    bus.h_out_valid          = 1'b1;
    bus.h_out_serialnum      = drv_q[0].serial;
    bus.h_out_data           = drv_q[0].data;
    bus.h_out_last_processed = drv_q[0].last;
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      chk("stall_h_out_ready", bus.h_out_ready, 0);
      chk("stall_m_valid", bus.m_valid, 4'b0010);
      chk("stall_m_data", bus.m_data[1], 96'h1111_2222_3333_4444_5555_6666);
      tick();
    end
    bus.m_ready = '1;
    run_ret(4);
    #1;
    chk("c_inflight", dut.inflight_q, model_cnt);
    tick();

    // mid-stream reset after the pointer has moved off source 0
    bus.s_valid = 4'hF;
    push_iss(3);
    push_iss(0);
    run_issue(6);
    reset               = 1'b1;
    bus.h_out_valid     = 1'b1;
    bus.h_out_serialnum = 64'h4000_0000_0000_0009;
    #1;
    chk("mrst_h_in_valid", bus.h_in_valid, 0);
    chk("mrst_s_ready", bus.s_ready, 0);
    chk("mrst_m_valid", bus.m_valid, 0);
    chk("mrst_h_out_ready", bus.h_out_ready, 0);
    tick();
    reset           = 1'b0;
    bus.s_valid     = '0;
    bus.h_out_valid = 1'b0;
    model_cnt       = 0;
    #1;
    chk("post_rst_h_in_valid", bus.h_in_valid, 0);
    chk("post_rst_m_valid", bus.m_valid, 0);
    chk("post_rst_inflight", dut.inflight_q, 0);
    chk("post_rst_busy", bus.busy, 0);
    tick();

    // six issues from source 0 onward, then six returns
    bus.s_valid = 4'hF;
    for (int unsigned k = 0; k < 6; k++) push_iss(k % 4);
    run_issue(12);
    bus.s_valid = '0;
    #1;
    chk("six_busy", bus.busy, 1);
    chk("six_inflight", dut.inflight_q, 6);
    for (int unsigned k = 0; k < 6; k++)
      push_ret(k % 4, 64'(k * 3 + 100), {32'(k), 64'hFEED_0000_0000_0000 | 64'(k)}, k[0]);
    run_ret(12);
    #1;
    chk("drain_inflight", dut.inflight_q, 0);
    chk("drain_busy", bus.busy, 0);
    tick();

    // counter saturation, simultaneous issue/return, floor at zero
    bus.s_valid = 4'hF;
    for (int unsigned k = 0; k < 17; k++) push_iss((2 + k) % 4);
    run_issue(30);
    bus.s_valid = '0;
    #1;
    chk("sat_inflight", dut.inflight_q, 15);
    tick();
    bus.s_valid         = 4'b0001;
    bus.h_out_valid     = 1'b1;
    bus.h_out_serialnum = 64'h0000_0000_0000_0042;
    #1;
    chk("both_xfer", {bus.h_in_valid, bus.h_out_ready}, 2'b11);
    tick();
    bus.s_valid     = '0;
    bus.h_out_valid = 1'b0;
    #1;
    chk("both_inflight", dut.inflight_q, 15);
    for (int unsigned k = 0; k < 16; k++)
      push_ret(3 - (k % 4), 64'(k + 500), 96'(k) << 40, 1'b0);
    run_ret(40);
    #1;
    chk("floor_inflight", dut.inflight_q, model_cnt);
    chk("floor_zero", dut.inflight_q, 0);
    tick();

    // source 1 runs a three-beat burst while source 0 also requests
    bus.s_last_processed = 4'b1101;
    bus.s_valid          = 4'b0011;
`ifdef MURMUR_ARB_LOCK_EN
    push_iss(1); push_iss(1); push_iss(1); push_iss(0);
`else
    push_iss(1); push_iss(0); push_iss(1); push_iss(0);
`endif
    beats1 = 0;
    n      = 0;
    while (iss_q.size() != 0 && n < 12) begin
      #1;
      if (bus.h_in_valid && bus.h_in_ready) begin
        iss_t       e;
        logic [3:0] oh;
        e        = iss_q.pop_front();
        oh       = '0;
        oh[e.id] = 1'b1;
        chk("lock_grant", bus.s_ready, oh);
        chk("lock_serial", bus.h_in_serialnum, e.serial);
        if (e.id == 1) beats1++;
        cnt_inc();
      end
      tick();
      n++;
      bus.s_last_processed[1] = (beats1 == 2);
    end
    if (iss_q.size() != 0) begin
      chk("lock_timeout", iss_q.size(), 0);
      iss_q.delete();
    end
    bus.s_valid = '0;

    // three-source build: id 3 has no destination and is dropped
    bus3.h_out_valid     = 1'b1;
    bus3.h_out_serialnum = 64'hC000_0000_0000_0011;
    #1;
    chk("drop_h_out_ready", bus3.h_out_ready, 1);
    chk("drop_m_valid", bus3.m_valid, 0);
    tick();
    #1;
    chk("drop_inflight", dut3.inflight_q, 0);
    bus3.h_out_serialnum = 64'h8000_0000_0000_0011;
    #1;
    chk("src2_h_out_ready", bus3.h_out_ready, 0);
    chk("src2_m_valid", bus3.m_valid, 3'b100);
    bus3.h_out_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
